// File: rtl/rvv_pkg.sv
// Shared constants and bus types for the vector-pair fetch path.
package rvv_pkg;
   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   localparam logic [31:0] INST_NOP = 32'h0000_0001;
   localparam int          InstBusW     = 32;
   localparam int          InstAddrBusW = 32;

   typedef logic [InstBusW-1:0]     inst_bus_t;
   typedef logic [InstAddrBusW-1:0] inst_addr_bus_t;
   // [0] = vector instruction, [1] = scalar operand word
   typedef inst_bus_t [1:0]         inst_pair_t;

   typedef struct packed {
      inst_addr_bus_t addr;
      logic [63:0]    data;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with combinational head; flush beats push and pop.
// Push into a full FIFO is only legal together with a pop.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 96
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_dat_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output logic [WIDTH-1:0]           head_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !flush_i;
   assign do_pop  = pop_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_i && !flush_i && full_o && !pop_i));
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC/credit control toward imem, in-order response buffer, one pair per cycle to IF/ID.
// Output is combinational from the buffer head; hold freezes it, requests stop when credits run out.
module inst_fetch
   import rvv_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_flag_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   output logic              req_valid_o,
   input  logic              req_ready_i,
   output logic [ADDR_W-1:0] req_addr_o,
   input  logic              resp_valid_i,
   input  logic [63:0]       resp_data_i,
   output inst_pair_t        inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              inst_valid_o
);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int SUM_W = CNT_W + 2;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(8);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [63:0]       data;
   } entry_t;

   logic [ADDR_W-1:0] pc_q, pc_d, rsp_addr_q, rsp_addr_d, jump_tgt;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d, discard_q, discard_d;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [SUM_W-1:0]  inflight;
   logic              fifo_full, fifo_empty;
   logic              req_fire, resp_drop, resp_keep, push, pop;
   entry_t            push_ent, head_ent;
   logic              unused_ok;

   assign jump_tgt  = {jump_addr_i[ADDR_W-1:3], 3'b000};
   assign unused_ok = ^{jump_addr_i[2:0], fifo_full};

   // Every slot that may still become a FIFO entry holds one credit.
   assign inflight    = SUM_W'(outstanding_q) + SUM_W'(fifo_cnt) + SUM_W'(discard_q);
   assign req_valid_o = !rst && !jump_flag_i && (inflight < SUM_W'(FIFO_DEPTH));
   assign req_addr_o  = pc_q;
   assign req_fire    = req_valid_o && req_ready_i;

   assign resp_drop = resp_valid_i && (discard_q != '0);
   assign resp_keep = resp_valid_i && (discard_q == '0);
   assign push      = resp_keep && !jump_flag_i;
   assign pop       = !hold_flag_i && !fifo_empty;

   assign push_ent.addr = rsp_addr_q;
   assign push_ent.data = resp_data_i;

   always_comb begin
      pc_d          = pc_q;
      rsp_addr_d    = rsp_addr_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      if (jump_flag_i) begin
         pc_d          = jump_tgt;
         rsp_addr_d    = jump_tgt;
         // A response landing this cycle retires one pending slot either way.
         discard_d     = discard_q + outstanding_q - CNT_W'(resp_valid_i);
         outstanding_d = '0;
      end else begin
         if (req_fire)  pc_d       = pc_q + STEP;
         if (push)      rsp_addr_d = rsp_addr_q + STEP;
         if (resp_drop) discard_d  = discard_q - CNT_W'(1);
         outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(push);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         rsp_addr_q    <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         pc_q          <= pc_d;
         rsp_addr_q    <= rsp_addr_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_ent),
      .pop_i      (pop),
      .flush_i    (jump_flag_i),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt),
      .head_o     (head_ent)
   );

   assign inst_valid_o = !fifo_empty;
   assign inst_o       = fifo_empty ? {ZeroWord, INST_NOP} : head_ent.data;
   assign inst_addr_o  = fifo_empty ? rsp_addr_q : head_ent.addr;

   a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
      !(resp_keep && outstanding_q == '0));
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: imem model with a scoreboard of issued addresses, one task per scenario.
module tb_inst_fetch;
   import rvv_pkg::*;

   logic        clk;
   logic        rst;
   logic        hold_flag_i, jump_flag_i, req_ready_i, resp_valid_i;
   logic [31:0] jump_addr_i, req_addr_o, inst_addr_o;
   logic [63:0] resp_data_i;
   logic        req_valid_o, inst_valid_o;
   inst_pair_t  inst_o;

   logic        w_hold, w_jump, w_ready, w_resp_valid;
   logic [31:0] w_jump_addr, w_req_addr, w_inst_addr;
   logic [63:0] w_resp_data;
   logic        w_req_valid, w_inst_valid;
   inst_pair_t  w_inst;

   logic        mem_go;
   logic [31:0] pend_q[$];
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   inst_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
      .jump_addr_i(jump_addr_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
      .req_addr_o(req_addr_o), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o));

   inst_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF0), .FIFO_DEPTH(4)) u_dut_wrap (
      .clk(clk), .rst(rst), .hold_flag_i(w_hold), .jump_flag_i(w_jump),
      .jump_addr_i(w_jump_addr), .req_valid_o(w_req_valid), .req_ready_i(w_ready),
      .req_addr_o(w_req_addr), .resp_valid_i(w_resp_valid), .resp_data_i(w_resp_data),
      .inst_o(w_inst), .inst_addr_o(w_inst_addr), .inst_valid_o(w_inst_valid));

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hC0DE_0000, ~a};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Imem: accepts at the edge, answers in order from the next cycle while mem_go is set.
   initial begin : imem
      logic [31:0] a;
      resp_valid_i = 1'b0;
      resp_data_i  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend_q.delete();
            exp_q.delete();
         end else if (req_valid_o && req_ready_i) begin
            pend_q.push_back(req_addr_o);
            exp_q.push_back(req_addr_o);
         end
         @(posedge clk);
         #2;
         if (!rst && mem_go && pend_q.size() > 0) begin
            a = pend_q.pop_front();
            resp_valid_i = 1'b1;
            resp_data_i  = mem_word(a);
         end else begin
            resp_valid_i = 1'b0;
         end
      end
   end

   // Scoreboard: every consumed output must be the oldest live request.
   initial begin : monitor
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && inst_valid_o && !hold_flag_i && !jump_flag_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL sb_unexpected: got addr %h, expected no output", inst_addr_o);
            end else begin
               e = exp_q.pop_front();
               if (inst_addr_o !== e)
                  $display("FAIL sb_addr: got %h expected %h", inst_addr_o, e);
               else n_pass++;
               n_checks++;
               if (inst_o !== mem_word(e))
                  $display("FAIL sb_data: got %h expected %h", inst_o, mem_word(e));
               else n_pass++;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; hold_flag_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0;
      req_ready_i = 1'b0; mem_go = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; hold_flag_i = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0;
      req_ready_i = 1'b1; mem_go = 1'b1;
      w_hold = 1'b0; w_jump = 1'b0; w_jump_addr = '0; w_ready = 1'b1;
      w_resp_valid = 1'b0; w_resp_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (req_valid_o !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", req_valid_o);
      else n_pass++;
      n_checks++;
      if (inst_valid_o !== 1'b0) $display("FAIL reset_inst_valid: got %b expected 0", inst_valid_o);
      else n_pass++;
      n_checks++;
      if (inst_o !== {ZeroWord, INST_NOP}) $display("FAIL reset_inst: got %h expected %h", inst_o, {ZeroWord, INST_NOP});
      else n_pass++;
      n_checks++;
      if (inst_addr_o !== 32'h0) $display("FAIL reset_inst_addr: got %h expected 0", inst_addr_o);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_stream();
      int first_rsp = -1, first_vld = -1, nfire = 0, nout = 0;
      do_reset();
      req_ready_i = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         if (req_valid_o && req_ready_i && nfire < 3) begin
            n_checks++;
            if (req_addr_o !== 32'(nfire * 8)) $display("FAIL stream_req_addr: got %h expected %h", req_addr_o, 32'(nfire * 8));
            else n_pass++;
            nfire++;
         end
         if (resp_valid_i && first_rsp < 0) first_rsp = cyc;
         if (inst_valid_o) begin
            if (first_vld < 0) first_vld = cyc;
            if (nout < 3) begin
               n_checks++;
               if (inst_addr_o !== 32'(nout * 8)) $display("FAIL stream_inst_addr: got %h expected %h", inst_addr_o, 32'(nout * 8));
               else n_pass++;
               nout++;
            end
         end
      end
      n_checks++;
      if (first_rsp < 0 || first_vld != first_rsp + 1)
         $display("FAIL stream_latency: got first valid cycle %0d expected %0d", first_vld, first_rsp + 1);
      else n_pass++;
      n_checks++;
      if (nfire != 3 || nout != 3) $display("FAIL stream_count: got fires %0d outs %0d expected 3 and 3", nfire, nout);
      else n_pass++;
   endtask

   task automatic test_backpressure_hold();
      do_reset();
      req_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (req_valid_o !== 1'b1 || req_addr_o !== 32'h0)
            $display("FAIL stall_req: got valid %b addr %h expected valid 1 addr 0", req_valid_o, req_addr_o);
         else n_pass++;
      end
      @(posedge clk);
      #1 hold_flag_i = 1'b1; req_ready_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         repeat (k == 0 ? 8 : 3) @(posedge clk);
         @(negedge clk);
         n_checks++;
         if (req_valid_o !== 1'b0) $display("FAIL hold_req_valid: got %b expected 0", req_valid_o);
         else n_pass++;
         n_checks++;
         if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== mem_word(32'h0))
            $display("FAIL hold_frozen: got valid %b addr %h inst %h expected 1 0 %h", inst_valid_o, inst_addr_o, inst_o, mem_word(32'h0));
         else n_pass++;
      end
      @(posedge clk);
      #1 hold_flag_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'(i * 8))
            $display("FAIL hold_release_pop: got valid %b addr %h expected 1 %h", inst_valid_o, inst_addr_o, 32'(i * 8));
         else n_pass++;
      end
   endtask

   task automatic test_jump();
      bit found = 0;
      do_reset();
      req_ready_i = 1'b1; mem_go = 1'b0;
      repeat (2) @(posedge clk);
      #1 req_ready_i = 1'b0;
      @(posedge clk);
      #1 jump_flag_i = 1'b1; jump_addr_i = 32'h0000_1004; mem_go = 1'b1; req_ready_i = 1'b1;
      @(negedge clk);
      n_checks++;
      if (req_valid_o !== 1'b0) $display("FAIL jump_cycle_req: got %b expected 0", req_valid_o);
      else n_pass++;
      exp_q.delete();
      @(posedge clk);
      #1 jump_flag_i = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (req_valid_o && req_ready_i) begin
            found = 1;
            n_checks++;
            if (req_addr_o !== 32'h0000_1000) $display("FAIL jump_req_addr: got %h expected 00001000", req_addr_o);
            else n_pass++;
         end
      end
      if (!found) begin
         n_checks++;
         $display("FAIL jump_req_timeout: got no request expected one at 00001000");
      end
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (inst_valid_o) begin
            found = 1;
            n_checks++;
            if (inst_addr_o !== 32'h0000_1000 || inst_o !== mem_word(32'h0000_1000))
               $display("FAIL jump_first_out: got addr %h inst %h expected 00001000 %h", inst_addr_o, inst_o, mem_word(32'h0000_1000));
            else n_pass++;
         end
      end
      if (!found) begin
         n_checks++;
         $display("FAIL jump_out_timeout: got no valid output expected addr 00001000");
      end
   endtask

   task automatic test_jump_hold_resp();
      bit found = 0;
      do_reset();
      req_ready_i = 1'b1; hold_flag_i = 1'b1;
      for (int k = 0; k < 10 && !found; k++) begin
         @(posedge clk);
         #3;
         if (resp_valid_i && inst_valid_o) found = 1;
      end
      if (!found) begin
         n_checks++;
         $display("FAIL jhr_setup_timeout: got no response with buffered entry expected one");
         return;
      end
      jump_flag_i = 1'b1; jump_addr_i = 32'h0000_0204; req_ready_i = 1'b0;
      @(negedge clk);
      exp_q.delete();
      @(posedge clk);
      #1 jump_flag_i = 1'b0;
      @(negedge clk);
      n_checks++;
      if (inst_valid_o !== 1'b0) $display("FAIL jhr_valid: got %b expected 0", inst_valid_o);
      else n_pass++;
      n_checks++;
      if (inst_o !== {ZeroWord, INST_NOP}) $display("FAIL jhr_inst: got %h expected %h", inst_o, {ZeroWord, INST_NOP});
      else n_pass++;
      n_checks++;
      if (inst_addr_o !== 32'h0000_0200) $display("FAIL jhr_addr: got %h expected 00000200", inst_addr_o);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (inst_valid_o !== 1'b0) $display("FAIL jhr_late_dropped: got %b expected 0", inst_valid_o);
      else n_pass++;
      @(posedge clk);
      #1 hold_flag_i = 1'b0; req_ready_i = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (inst_valid_o) begin
            found = 1;
            n_checks++;
            if (inst_addr_o !== 32'h0000_0200) $display("FAIL jhr_first_out: got %h expected 00000200", inst_addr_o);
            else n_pass++;
         end
      end
      if (!found) begin
         n_checks++;
         $display("FAIL jhr_out_timeout: got no valid output expected addr 00000200");
      end
   endtask

   task automatic test_wrap();
      logic [31:0] wexp [3] = '{32'hFFFF_FFF0, 32'hFFFF_FFF8, 32'h0000_0000};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (w_req_valid !== 1'b1 || w_req_addr !== wexp[i])
            $display("FAIL wrap_req: got valid %b addr %h expected 1 %h", w_req_valid, w_req_addr, wexp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_mid_reset();
      bit found = 0;
      do_reset();
      req_ready_i = 1'b1; hold_flag_i = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (req_valid_o !== 1'b0 || inst_valid_o !== 1'b0)
         $display("FAIL mrst_valids: got req %b inst %b expected 0 0", req_valid_o, inst_valid_o);
      else n_pass++;
      n_checks++;
      if (inst_o !== {ZeroWord, INST_NOP} || inst_addr_o !== 32'h0)
         $display("FAIL mrst_outputs: got inst %h addr %h expected %h 0", inst_o, inst_addr_o, {ZeroWord, INST_NOP});
      else n_pass++;
      n_checks++;
      if (req_addr_o !== 32'h0) $display("FAIL mrst_pc: got %h expected 0", req_addr_o);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0; hold_flag_i = 1'b0;
      for (int k = 0; k < 5 && !found; k++) begin
         @(negedge clk);
         if (req_valid_o && req_ready_i) begin
            found = 1;
            n_checks++;
            if (req_addr_o !== 32'h0) $display("FAIL mrst_first_req: got %h expected 0", req_addr_o);
            else n_pass++;
         end
      end
      if (!found) begin
         n_checks++;
         $display("FAIL mrst_req_timeout: got no request expected one at 0");
      end
      repeat (10) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure_hold();
      test_jump();
      test_jump_hold_resp();
      test_wrap();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
